// File: rtl/axi4_r_drop_arbiter.sv
// Shares the slave AXI4 R channel between forwarded master read beats and locally
// generated error/OKAY bursts for transactions the RAB refused.
module axi4_r_drop_arbiter #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_USER_WIDTH = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      axi4_aclk,
    input  logic                      axi4_arstn,

    input  logic                      req0_valid,
    output logic                      req0_ready,
    input  logic [AXI_ID_WIDTH-1:0]   req0_id,
    input  logic [7:0]                req0_len,
    input  logic                      req0_prefetch,

    input  logic                      req1_valid,
    output logic                      req1_ready,
    input  logic [AXI_ID_WIDTH-1:0]   req1_id,
    input  logic [7:0]                req1_len,
    input  logic                      req1_prefetch,

    input  logic [AXI_ID_WIDTH-1:0]   m_axi4_rid,
    input  logic [AXI_DATA_WIDTH-1:0] m_axi4_rdata,
    input  logic [1:0]                m_axi4_rresp,
    input  logic                      m_axi4_rlast,
    input  logic [AXI_USER_WIDTH-1:0] m_axi4_ruser,
    input  logic                      m_axi4_rvalid,
    output logic                      m_axi4_rready,

    output logic [AXI_ID_WIDTH-1:0]   s_axi4_rid,
    output logic [AXI_DATA_WIDTH-1:0] s_axi4_rdata,
    output logic [1:0]                s_axi4_rresp,
    output logic                      s_axi4_rlast,
    output logic [AXI_USER_WIDTH-1:0] s_axi4_ruser,
    output logic                      s_axi4_rvalid,
    input  logic                      s_axi4_rready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic                    prefetch;
        logic [AXI_ID_WIDTH-1:0] id;
        logic [7:0]              len;
    } drop_entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FWD,
        S_DROP
    } state_t;

    state_t            state;
    logic [7:0]        beat_cnt;
    logic              prio;
    logic              grant0;
    logic              grant1;

    drop_entry_t       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fill;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    drop_entry_t       push_entry;
    drop_entry_t       head;

    logic              drop_active;
    logic [7:0]        beat_idx;
    logic              drop_last;

    assign fifo_full  = (fill == FULL_CNT);
    assign fifo_empty = (fill == '0);
    assign head       = mem[rd_ptr];

    // Round-robin: a lone requester always wins; on contention the pointer decides.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!fifo_full) begin
            if (req0_valid && (!req1_valid || !prio))
                grant0 = 1'b1;
            else if (req1_valid)
                grant1 = 1'b1;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign push       = grant0 | grant1;
    assign push_entry = grant1 ? drop_entry_t'{req1_prefetch, req1_id, req1_len}
                               : drop_entry_t'{req0_prefetch, req0_id, req0_len};

    // A drop owns the channel in DROP, or in IDLE whenever a head is waiting.
    assign drop_active = (state == S_DROP) || ((state == S_IDLE) && !fifo_empty);
    assign beat_idx    = (state == S_DROP) ? beat_cnt : 8'd0;
    assign drop_last   = (beat_idx == head.len);
    assign pop         = drop_active && s_axi4_rready && drop_last;

    always_comb begin
        if (drop_active) begin
            s_axi4_rid    = head.id;
            s_axi4_rdata  = '0;
            s_axi4_rresp  = head.prefetch ? 2'b00 : 2'b10;
            s_axi4_rlast  = drop_last;
            s_axi4_ruser  = '0;
            s_axi4_rvalid = 1'b1;
            m_axi4_rready = 1'b0;
        end else begin
            s_axi4_rid    = m_axi4_rid;
            s_axi4_rdata  = m_axi4_rdata;
            s_axi4_rresp  = m_axi4_rresp;
            s_axi4_rlast  = m_axi4_rlast;
            s_axi4_ruser  = m_axi4_ruser;
            s_axi4_rvalid = m_axi4_rvalid;
            m_axi4_rready = s_axi4_rready;
        end
    end

    // NOTE: the storage array has no reset; only pointers and fill level define validity.
    always_ff @(posedge axi4_aclk) begin
        if (push)
            mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
            prio   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
            if (grant0)
                prio <= 1'b1;
            else if (grant1)
                prio <= 1'b0;
        end
    end

    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            state    <= S_IDLE;
            beat_cnt <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        if (s_axi4_rready && (head.len != 8'd0)) begin
                            beat_cnt <= 8'd1;
                            state    <= S_DROP;
                        end
                    end else if (m_axi4_rvalid && !(s_axi4_rready && m_axi4_rlast)) begin
                        state <= S_FWD;
                    end
                end
                S_FWD: begin
                    if (m_axi4_rvalid && s_axi4_rready && m_axi4_rlast)
                        state <= S_IDLE;
                end
                S_DROP: begin
                    if (s_axi4_rready) begin
                        if (drop_last) begin
                            beat_cnt <= 8'd0;
                            state    <= S_IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    beat_cnt <= 8'd0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_r_drop_arbiter.sv
// Directed bench for axi4_r_drop_arbiter: drop bursts, forwarding, arbitration,
// FIFO-full back-pressure, len=255 and asynchronous reset mid-drop.
module tb_axi4_r_drop_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_prefetch;
    logic        req1_valid, req1_ready, req1_prefetch;
    logic [3:0]  req0_id, req1_id;
    logic [7:0]  req0_len, req1_len;
    logic [3:0]  m_rid, s_rid;
    logic [31:0] m_rdata, s_rdata;
    logic [1:0]  m_rresp, s_rresp;
    logic        m_rlast, s_rlast;
    logic [3:0]  m_ruser, s_ruser;
    logic        m_rvalid, m_rready, s_rvalid, s_rready;

    int checks;
    int failures;

    axi4_r_drop_arbiter #(
        .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(4), .FIFO_DEPTH(4)
    ) dut (
        .axi4_aclk     (clk),
        .axi4_arstn    (rst_n),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req0_id       (req0_id),
        .req0_len      (req0_len),
        .req0_prefetch (req0_prefetch),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .req1_id       (req1_id),
        .req1_len      (req1_len),
        .req1_prefetch (req1_prefetch),
        .m_axi4_rid    (m_rid),
        .m_axi4_rdata  (m_rdata),
        .m_axi4_rresp  (m_rresp),
        .m_axi4_rlast  (m_rlast),
        .m_axi4_ruser  (m_ruser),
        .m_axi4_rvalid (m_rvalid),
        .m_axi4_rready (m_rready),
        .s_axi4_rid    (s_rid),
        .s_axi4_rdata  (s_rdata),
        .s_axi4_rresp  (s_rresp),
        .s_axi4_rlast  (s_rlast),
        .s_axi4_ruser  (s_ruser),
        .s_axi4_rvalid (s_rvalid),
        .s_axi4_rready (s_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  beats;
        bit  done;
        checks   = 0;
        failures = 0;
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_id = '0; req0_len = '0; req0_prefetch = 1'b0;
        req1_valid = 1'b0; req1_id = '0; req1_len = '0; req1_prefetch = 1'b0;
        m_rid = 4'h7; m_rdata = 32'h1234_5678; m_rresp = 2'b01; m_rlast = 1'b1;
        m_ruser = 4'h9; m_rvalid = 1'b1; s_rready = 1'b1;

        // Reset: pure pass-through of the master channel.
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_rvalid", s_rvalid, 1);
        check("rst_s_rid", s_rid, 4'h7);
        check("rst_s_rdata", s_rdata, 32'h1234_5678);
        check("rst_s_rresp", s_rresp, 2'b01);
        check("rst_s_ruser", s_ruser, 4'h9);
        check("rst_m_rready", m_rready, 1);
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        check("rst_s_rvalid_low", s_rvalid, 0);
        rst_n = 1'b1;
        tick();

        // Single SLVERR drop from req0.
        req0_valid = 1'b1; req0_id = 4'h3; req0_len = 8'd0; req0_prefetch = 1'b0;
        #1;
        check("t1_req0_ready", req0_ready, 1);
        check("t1_no_beat_yet", s_rvalid, 0);
        tick();
        req0_valid = 1'b0;
        #1;
        check("t1_rvalid", s_rvalid, 1);
        check("t1_rid", s_rid, 4'h3);
        check("t1_rresp", s_rresp, 2'b10);
        check("t1_rlast", s_rlast, 1);
        check("t1_rdata", s_rdata, 0);
        check("t1_m_rready", m_rready, 0);
        tick();
        check("t1_done", s_rvalid, 0);

        // Prefetch burst len=3 from req1 with a slave stall on beat 0.
        req1_valid = 1'b1; req1_id = 4'h5; req1_len = 8'd3; req1_prefetch = 1'b1;
        tick();
        req1_valid = 1'b0; s_rready = 1'b0;
        #1;
        check("t2_b0_rid", s_rid, 4'h5);
        check("t2_b0_rlast", s_rlast, 0);
        tick();
        check("t2_stall_rvalid", s_rvalid, 1);
        check("t2_stall_fields", {s_rid, s_rresp, s_rlast, s_rdata}, {4'h5, 2'b00, 1'b0, 32'h0});
        s_rready = 1'b1;
        tick();
        check("t2_b1", {s_rvalid, s_rid, s_rresp, s_rlast}, {1'b1, 4'h5, 2'b00, 1'b0});
        tick();
        check("t2_b2", {s_rvalid, s_rid, s_rresp, s_rlast}, {1'b1, 4'h5, 2'b00, 1'b0});
        tick();
        check("t2_b3", {s_rvalid, s_rid, s_rresp, s_rlast}, {1'b1, 4'h5, 2'b00, 1'b1});
        check("t2_b3_m_rready", m_rready, 0);
        tick();
        check("t2_done", s_rvalid, 0);

        // Master burst id=1 len=7; a drop request lands after beat 4 and must wait.
        for (int i = 0; i < 8; i++) begin
            m_rvalid = 1'b1; m_rid = 4'h1; m_rdata = 32'(i); m_rresp = 2'b00;
            m_rlast = (i == 7); m_ruser = 4'h0;
            if (i == 4) begin
                req0_valid = 1'b1; req0_id = 4'h9; req0_len = 8'd1; req0_prefetch = 1'b0;
            end else begin
                req0_valid = 1'b0;
            end
            #1;
            check("t3_fwd", {s_rvalid, s_rid, s_rdata, s_rlast, m_rready},
                  {1'b1, 4'h1, 32'(i), (i == 7), 1'b1});
            if (i == 4) check("t3_req0_ready", req0_ready, 1);
            tick();
        end
        req0_valid = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        check("t3_drop_b0", {s_rvalid, s_rid, s_rresp, s_rlast, m_rready},
              {1'b1, 4'h9, 2'b10, 1'b0, 1'b0});
        tick();
        check("t3_drop_b1", {s_rvalid, s_rid, s_rresp, s_rlast}, {1'b1, 4'h9, 2'b10, 1'b1});
        tick();
        check("t3_done", s_rvalid, 0);

        // Master valid while a drop is queued in IDLE: drop first, master stalled.
        req1_valid = 1'b1; req1_id = 4'h2; req1_len = 8'd0; req1_prefetch = 1'b1;
        tick();
        req1_valid = 1'b0;
        m_rvalid = 1'b1; m_rid = 4'h6; m_rdata = 32'hAA; m_rlast = 1'b1; m_rresp = 2'b00;
        #1;
        check("t5_drop_first", {s_rvalid, s_rid, s_rresp, s_rlast, m_rready},
              {1'b1, 4'h2, 2'b00, 1'b1, 1'b0});
        tick();
        check("t5_master_after", {s_rvalid, s_rid, s_rdata, m_rready},
              {1'b1, 4'h6, 32'hAA, 1'b1});
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0;

        // Both requesters for 6 cycles with no slave ready: alternate, then full.
        s_rready = 1'b0;
        req0_valid = 1'b1; req0_id = 4'hA; req0_len = 8'd0; req0_prefetch = 1'b0;
        req1_valid = 1'b1; req1_id = 4'hB; req1_len = 8'd0; req1_prefetch = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            check("t4_req0_ready", req0_ready, (c == 0 || c == 2));
            check("t4_req1_ready", req1_ready, (c == 1 || c == 3));
            tick();
        end
        check("t4_head", {s_rvalid, s_rid}, {1'b1, 4'hA});
        s_rready = 1'b1;
        #1;
        check("t4_full_same_cycle_pop", {req0_ready, req1_ready}, 2'b00);
        tick();
        check("t4_resume", {req0_ready, req1_ready}, 2'b10);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        check("t4_drain1", {s_rvalid, s_rid}, {1'b1, 4'hB});
        tick();
        check("t4_drain2", {s_rvalid, s_rid}, {1'b1, 4'hA});
        tick();
        check("t4_drain3", {s_rvalid, s_rid}, {1'b1, 4'hB});
        tick();
        check("t4_empty", s_rvalid, 0);

        // len=255 yields exactly 256 beats with rlast only on the last.
        req1_valid = 1'b1; req1_id = 4'hE; req1_len = 8'd255; req1_prefetch = 1'b1;
        tick();
        req1_valid = 1'b0;
        beats = 0;
        done  = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            if (s_rvalid && s_rid == 4'hE) beats++;
            if (s_rvalid && s_rlast) done = 1'b1;
            tick();
        end
        check("t7_rlast_seen", done, 1);
        check("t7_beats", beats, 256);
        check("t7_done", s_rvalid, 0);

        // Asynchronous reset at beat 2 of a len=5 drop with another drop queued.
        req0_valid = 1'b1; req0_id = 4'hC; req0_len = 8'd5; req0_prefetch = 1'b0;
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_id = 4'hD; req1_len = 8'd0; req1_prefetch = 1'b0;
        tick();
        req1_valid = 1'b0;
        tick();
        check("t6_beat2", {s_rvalid, s_rid, s_rlast}, {1'b1, 4'hC, 1'b0});
        m_rvalid = 1'b1; m_rid = 4'h3; m_rdata = 32'h55; m_rlast = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t6_rst_pass", {s_rvalid, s_rid, s_rdata, m_rready}, {1'b1, 4'h3, 32'h55, 1'b1});
        #1;
        rst_n = 1'b1;
        m_rvalid = 1'b0;
        req0_valid = 1'b1; req0_id = 4'h1; req0_len = 8'd0;
        #1;
        check("t6_fifo_empty", s_rvalid, 0);
        check("t6_req0_ready", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        #1;
        check("t6_new_drop", {s_rvalid, s_rid, s_rlast}, {1'b1, 4'h1, 1'b1});
        tick();
        check("t6_final_empty", s_rvalid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi4_r_drop_arbiter.md
# axi4_r_drop_arbiter

Shares the slave-side AXI4 R channel between read responses forwarded from the master port and locally generated drop responses for transactions the RAB refused (L1 miss / protection fault from requester 0, L2 TLB miss or prefetch from requester 1). Round-robin arbitration between the two drop requesters feeds a small FIFO. A burst-aware scheduler then injects a full-length error or OKAY burst (len+1 beats) per drop, only at master burst boundaries. The block sits between the master R port and the slave R port of the RAB slice.

## Interface
- AXI_DATA_WIDTH, 32, R data width
- AXI_ID_WIDTH, 4, ID width
- AXI_USER_WIDTH, 4, R user width
- FIFO_DEPTH, 4, drop FIFO entries; power of two, >= 2

Ports:
- axi4_aclk  in  1  clock
- axi4_arstn  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  drop request valid
- req0_ready / req1_ready  out  1  drop request accepted
- req0_id / req1_id  in  AXI_ID_WIDTH  ID of the dropped transaction
- req0_len / req1_len  in  8  AXI ARLEN of the dropped transaction
- req0_prefetch / req1_prefetch  in  1  1 = answer OKAY, 0 = answer SLVERR
- m_axi4_rid, m_axi4_rdata, m_axi4_rresp[1:0], m_axi4_rlast, m_axi4_ruser, m_axi4_rvalid  in  -  master R channel
- m_axi4_rready  out  1  master R ready
- s_axi4_rid, s_axi4_rdata, s_axi4_rresp[1:0], s_axi4_rlast, s_axi4_ruser, s_axi4_rvalid  out  -  slave R channel
- s_axi4_rready  in  1  slave R ready

## Operation
- Arbiter: FIFO not full and exactly one reqN_valid -> grant it. Both valid -> grant the requester named by the priority pointer. One grant per cycle. reqN_ready = granted & FIFO not full. On each grant the pointer moves to the other requester. The pointer resets to requester 0.
- FIFO stores {prefetch, id, len}. Registered, no bypass. Ready depends only on the current fill level, not on a same-cycle pop. Simultaneous push and pop leaves the count unchanged. Occupancy counter is clog2(FIFO_DEPTH)+1 bits.
- Beat counter: 8 bits. It counts the current drop beat index 0..len.
- FSM states:
  - IDLE
    - FIFO non-empty: drive drop beat 0. If the beat is accepted and len==0, pop and stay in IDLE. If accepted and len>0, set counter=1 and go to DROP. If not accepted, hold.
    - FIFO empty: forward the master beat combinationally. If m_axi4_rvalid is set and the beat is not (accepted with rlast), go to FWD.
  - FWD: forward master beats. Go to IDLE on an accepted beat with m_axi4_rlast=1. A drop is never inserted inside a master burst.
  - DROP: drive the beat at the counter index. On acceptance: counter==len -> pop and go to IDLE; else counter+1.
- Drop beat fields:
  - rid = entry id
  - rdata = 0
  - ruser = 0
  - rresp = prefetch ? 2'b00 : 2'b10
  - rlast = (index == len)
  - rvalid = 1
- Forwarding: all s_axi4_r* fields = m_axi4_r*. m_axi4_rready = s_axi4_rready. In any drop cycle m_axi4_rready = 0.
- Stability: a drop beat that is not accepted stays bit-identical until it is accepted. The FIFO head changes only on pop. A stalled master beat locks the FSM in FWD.

## Timing
- Reset values and reset behaviour:
  - State IDLE, FIFO empty, counter 0, pointer 0.
  - s_axi4_rvalid = m_axi4_rvalid; all other s_axi4_r* are a combinational pass-through. This is the IDLE/empty state.
  - Reset mid-burst discards all queued and in-progress drops immediately (asynchronous).
- Request accepted in cycle T -> first drop beat visible in T+1, provided the FSM is in IDLE then.
- Throughput: one beat per cycle on either source. Back-to-back drops need no bubble: last beat accepted -> pop, IDLE, and the next head is presented in the following cycle.
- FIFO full: both readys are 0. Pushing resumes the cycle after a pop.
- Boundary cases:
  - len=255 produces 256 beats; the counter does not wrap before rlast.
  - Drop pending while a master burst is stalled mid-way: the drop waits until the master rlast is accepted.

## Test plan
- Single drop, req0 id=3 len=0 prefetch=0, s_rready=1 -> one beat rid=3 rresp=2'b10 rlast=1 rdata=0, one cycle after acceptance. m_axi4_rready=0 in that cycle.
- Prefetch burst, req1 id=5 len=3 prefetch=1 -> 4 beats rresp=00 rid=5, rlast only on beat 4. A random s_rready stall holds every field stable.
- Master burst in progress: id=1 len=7, 4 beats done, then a drop request arrives -> remaining master beats 5-8 pass first, then the drop burst follows. Interleaving is a test failure.
- Both requesters valid for 6 consecutive cycles with FIFO_DEPTH=4 and s_rready=0 -> grants alternate req0, req1, req0, req1, then both readys stay 0 until the first pop.
- Master rvalid and FIFO non-empty together in IDLE -> drop served first, master stalled with m_rready=0, then master forwarded.
- Assert reset during DROP at beat 2 of len=5 -> next cycle s_axi4_rvalid follows m_axi4_rvalid, the FIFO is empty and req0_ready=1.
